// File: rtl/ddr_ahb_csr_bank.sv
// AHB-Lite slave with a built-in CSR bank: RW config words, RO status words,
// one sticky W1C event word with an interrupt mask, optional wait states.
module ddr_ahb_csr_bank #(
  parameter int AWIDTH      = 32,
  parameter int DWIDTH      = 32,
  parameter int NCFG        = 16,
  parameter int NSTA        = 8,
  parameter int WAIT_STATES = 0,
  parameter logic [NCFG*DWIDTH-1:0] CFG_RST = '0
) (
  input  logic                                   i_hclk,
  input  logic                                   i_hreset,
  input  logic [AWIDTH-1:0]                      i_haddr,
  input  logic                                   i_hwrite,
  input  logic                                   i_hsel,
  input  logic [DWIDTH-1:0]                      i_hwdata,
  input  logic [1:0]                             i_htrans,
  input  logic [2:0]                             i_hsize,
  input  logic [2:0]                             i_hburst,
  input  logic                                   i_hreadyin,
  output logic                                   o_hready,
  output logic [DWIDTH-1:0]                      o_hrdata,
  output logic [1:0]                             o_hresp,
  output logic [NCFG*DWIDTH-1:0]                 o_cfg,
  input  logic [((NSTA > 0) ? NSTA : 1)*DWIDTH-1:0] i_sta,
  input  logic [DWIDTH-1:0]                      i_evt,
  output logic                                   o_irq,
  output logic [2:0]                             o_dbg_state
);

  localparam int BYTES = DWIDTH / 8;
  localparam int ALSB  = $clog2(BYTES);
  localparam logic [AWIDTH-1:0] EVT_IDX  = AWIDTH'(NCFG + NSTA);
  localparam logic [AWIDTH-1:0] MASK_IDX = AWIDTH'(NCFG + NSTA + 1);
  localparam logic [1:0]        WS_LAST  = 2'(WAIT_STATES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } fsm_state_e;

  fsm_state_e                state_q, state_d;
  logic [1:0]                cnt_q, cnt_d;
  logic [AWIDTH-1:0]         a_addr;
  logic                      a_write;
  logic [2:0]                a_size;
  logic                      load;
  logic [NCFG*DWIDTH-1:0]    cfg_q;
  logic [DWIDTH-1:0]         evt_q, mask_q, w1c, lane_mask, rdata;
  logic                      irq_q;
  logic [BYTES-1:0]          lane_en;
  logic [AWIDTH-1:0]         widx, dec_idx, size_mask;
  logic                      accept, dec_err, do_wr;

  // Handshake: an address phase is taken when hsel & hreadyin & htrans[1] while the
  // slave is ready (IDLE, final DATA cycle or ERR2); the data phase ends in the
  // first cycle with o_hready high, which is when reads are valid and writes commit.
  assign accept  = i_hsel & i_hreadyin & i_htrans[1] &
                   ((state_q == S_IDLE) | (state_q == S_DATA) | (state_q == S_ERR2));
  assign dec_idx   = i_haddr >> ALSB;
  assign size_mask = (AWIDTH'(1) << i_hsize) - AWIDTH'(1);
  assign dec_err   = (dec_idx > MASK_IDX) | (i_hsize > 3'(ALSB)) | (|(i_haddr & size_mask));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == WS_LAST) state_d = S_DATA;
        else                  cnt_d   = cnt_q + 2'd1;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          load  = 1'b1;
          cnt_d = 2'd0;
          if (dec_err)              state_d = S_ERR1;
          else if (WAIT_STATES > 0) state_d = S_WAIT;
          else                      state_d = S_DATA;
        end
      end
    endcase
  end

  always_ff @(posedge i_hclk or negedge i_hreset) begin
    if (!i_hreset) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      a_addr  <= '0;
      a_write <= 1'b0;
      a_size  <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        a_addr  <= i_haddr;
        a_write <= i_hwrite;
        a_size  <= i_hsize;
      end
    end
  end

  assign widx  = a_addr >> ALSB;
  assign do_wr = (state_q == S_DATA) & a_write;

  // A lane is enabled when it falls in the same size-aligned block as the address.
  always_comb begin
    lane_en   = '0;
    lane_mask = '0;
    for (int b = 0; b < BYTES; b++) begin
      lane_en[b] = ((8'(b) >> a_size) == (8'(a_addr[ALSB-1:0]) >> a_size));
      lane_mask[b*8 +: 8] = {8{lane_en[b]}};
    end
  end

  assign w1c = (do_wr && (widx == EVT_IDX)) ? (i_hwdata & lane_mask) : '0;

  always_ff @(posedge i_hclk or negedge i_hreset) begin
    if (!i_hreset) begin
      cfg_q  <= CFG_RST;
      evt_q  <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      for (int k = 0; k < NCFG; k++)
        for (int b = 0; b < BYTES; b++)
          if (do_wr && (widx == AWIDTH'(k)) && lane_en[b])
            cfg_q[k*DWIDTH + b*8 +: 8] <= i_hwdata[b*8 +: 8];
      for (int b = 0; b < BYTES; b++)
        if (do_wr && (widx == MASK_IDX) && lane_en[b])
          mask_q[b*8 +: 8] <= i_hwdata[b*8 +: 8];
      evt_q <= (evt_q & ~w1c) | i_evt;
      irq_q <= |(evt_q & mask_q);
    end
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < NCFG; k++)
      if (widx == AWIDTH'(k)) rdata = cfg_q[k*DWIDTH +: DWIDTH];
    for (int k = 0; k < NSTA; k++)
      if (widx == AWIDTH'(NCFG + k)) rdata = i_sta[k*DWIDTH +: DWIDTH];
    if (widx == EVT_IDX)  rdata = evt_q;
    if (widx == MASK_IDX) rdata = mask_q;
  end

  assign o_hrdata    = ((state_q == S_DATA) && !a_write) ? rdata : '0;
  assign o_hready    = (state_q != S_WAIT) && (state_q != S_ERR1);
  assign o_hresp     = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? 2'b01 : 2'b00;
  assign o_cfg       = cfg_q;
  assign o_irq       = irq_q;
  assign o_dbg_state = state_q;

  logic unused_ok;
  assign unused_ok = ^{i_hburst, i_htrans[0]};

endmodule

// File: tb/tb_ddr_ahb_csr_bank.sv
// Bench for ddr_ahb_csr_bank: one instance with two wait states, one with none,
// sharing the bus; read data is checked against a scoreboard queue.
module tb_ddr_ahb_csr_bank;

  localparam int NCFG = 4;
  localparam int NSTA = 2;
  localparam logic [NCFG*32-1:0] CFG_INIT = {32'h0, 32'h0, 32'h0, 32'hDEADBEEF};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] haddr = '0;
  logic        hwrite = 1'b0;
  logic [1:0]  hsel = '0;
  logic [31:0] hwdata = '0;
  logic [1:0]  htrans = '0;
  logic [2:0]  hsize = '0;
  logic [2:0]  hburst = '0;
  logic [NSTA*32-1:0] sta = '0;
  logic [31:0] evt = '0;

  logic             hready_w [2];
  logic [31:0]      hrdata_w [2];
  logic [1:0]       hresp_w  [2];
  logic [NCFG*32-1:0] cfg_w  [2];
  logic             irq_w    [2];
  logic [2:0]       dbg_w    [2];

  int exp_ws [2] = '{0, 2};
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ddr_ahb_csr_bank #(.AWIDTH(32), .DWIDTH(32), .NCFG(NCFG), .NSTA(NSTA),
                     .WAIT_STATES(0), .CFG_RST(CFG_INIT)) u_ws0 (
    .i_hclk(clk), .i_hreset(rst_n), .i_haddr(haddr), .i_hwrite(hwrite),
    .i_hsel(hsel[0]), .i_hwdata(hwdata), .i_htrans(htrans), .i_hsize(hsize),
    .i_hburst(hburst), .i_hreadyin(hready_w[0]), .o_hready(hready_w[0]),
    .o_hrdata(hrdata_w[0]), .o_hresp(hresp_w[0]), .o_cfg(cfg_w[0]),
    .i_sta(sta), .i_evt(evt), .o_irq(irq_w[0]), .o_dbg_state(dbg_w[0]));

  ddr_ahb_csr_bank #(.AWIDTH(32), .DWIDTH(32), .NCFG(NCFG), .NSTA(NSTA),
                     .WAIT_STATES(2), .CFG_RST(CFG_INIT)) u_ws2 (
    .i_hclk(clk), .i_hreset(rst_n), .i_haddr(haddr), .i_hwrite(hwrite),
    .i_hsel(hsel[1]), .i_hwdata(hwdata), .i_htrans(htrans), .i_hsize(hsize),
    .i_hburst(hburst), .i_hreadyin(hready_w[1]), .o_hready(hready_w[1]),
    .o_hrdata(hrdata_w[1]), .o_hresp(hresp_w[1]), .o_cfg(cfg_w[1]),
    .i_sta(sta), .i_evt(evt), .o_irq(irq_w[1]), .o_dbg_state(dbg_w[1]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One transfer, called just after a rising edge; returns just after the edge ending it.
  task automatic ahb_xfer(input int d, input logic [31:0] addr, input logic wr,
                          input logic [2:0] size, input logic [31:0] wdata,
                          input logic exp_err, input logic [31:0] exp_rd,
                          input logic [31:0] evt_pulse);
    int lows;
    haddr = addr; hwrite = wr; hsize = size; htrans = 2'b10; hsel[d] = 1'b1;
    if (!wr && !exp_err) exp_q.push_back(exp_rd);
    @(posedge clk); #1;
    htrans = 2'b00; hsel[d] = 1'b0; hwdata = wdata;
    if (exp_err) begin
      check("err1_resp", 64'(hresp_w[d]), 64'h1);
      check("err1_ready", 64'(hready_w[d]), 64'h0);
      @(posedge clk); #1;
      check("err2_resp", 64'(hresp_w[d]), 64'h1);
      check("err2_ready", 64'(hready_w[d]), 64'h1);
      @(posedge clk); #1;
      check("err_after_resp", 64'(hresp_w[d]), 64'h0);
    end else begin
      lows = 0;
      while (hready_w[d] === 1'b0 && lows < 8) begin
        lows++;
        @(posedge clk); #1;
      end
      check("wait_cycles", 64'(lows), 64'(exp_ws[d]));
      check("okay_resp", 64'(hresp_w[d]), 64'h0);
      if (!wr) begin
        if (exp_q.size() == 0) check("sb_underflow", 64'h1, 64'h0);
        else check("rdata", 64'(hrdata_w[d]), 64'(exp_q.pop_front()));
      end
      evt = evt_pulse;
      @(posedge clk); #1;
      evt = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_cfg0", 64'(cfg_w[1][31:0]), 64'hDEADBEEF);
    check("rst_cfg0_ws0", 64'(cfg_w[0][31:0]), 64'hDEADBEEF);
    check("rst_ready", 64'(hready_w[1]), 64'h1);
    check("rst_resp", 64'(hresp_w[1]), 64'h0);
    check("rst_irq", 64'(irq_w[1]), 64'h0);
    check("rst_rdata", 64'(hrdata_w[1]), 64'h0);
    check("rst_state", 64'(dbg_w[1]), 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Word, byte and halfword writes on the two-wait-state slave.
    ahb_xfer(1, 32'h4, 1'b1, 3'd2, 32'h11223344, 1'b0, '0, '0);
    ahb_xfer(1, 32'h6, 1'b1, 3'd0, 32'hAAAAAAAA, 1'b0, '0, '0);
    check("cfg1_port", 64'(cfg_w[1][63:32]), 64'h11AA3344);
    ahb_xfer(1, 32'h4, 1'b0, 3'd2, '0, 1'b0, 32'h11AA3344, '0);
    ahb_xfer(1, 32'hA, 1'b1, 3'd1, 32'hBEEFBEEF, 1'b0, '0, '0);
    ahb_xfer(1, 32'h8, 1'b0, 3'd2, '0, 1'b0, 32'hBEEF0000, '0);

    // Status words: reads follow i_sta, writes are ignored.
    sta = {32'h00000000, 32'h5A5A0001};
    ahb_xfer(1, 32'(NCFG*4), 1'b0, 3'd2, '0, 1'b0, 32'h5A5A0001, '0);
    ahb_xfer(1, 32'(NCFG*4), 1'b1, 3'd2, 32'hFFFFFFFF, 1'b0, '0, '0);
    ahb_xfer(1, 32'(NCFG*4), 1'b0, 3'd2, '0, 1'b0, 32'h5A5A0001, '0);

    // Error decodes: out of range, misaligned, oversized.
    ahb_xfer(1, 32'((NCFG+NSTA+2)*4), 1'b0, 3'd2, '0, 1'b1, '0, '0);
    ahb_xfer(1, 32'h2, 1'b1, 3'd2, 32'h0, 1'b1, '0, '0);
    ahb_xfer(1, 32'h0, 1'b1, 3'd3, 32'h0, 1'b1, '0, '0);
    check("err_no_side_cfg0", 64'(cfg_w[1][31:0]), 64'hDEADBEEF);
    ahb_xfer(1, 32'h4, 1'b0, 3'd2, '0, 1'b0, 32'h11AA3344, '0);

    // Events and interrupt.
    ahb_xfer(1, 32'((NCFG+NSTA+1)*4), 1'b1, 3'd2, 32'h4, 1'b0, '0, '0);
    evt = 32'h4;
    @(posedge clk); #1;
    evt = '0;
    check("irq_lag1", 64'(irq_w[1]), 64'h0);
    @(posedge clk); #1;
    check("irq_set", 64'(irq_w[1]), 64'h1);
    ahb_xfer(1, 32'((NCFG+NSTA)*4), 1'b0, 3'd2, '0, 1'b0, 32'h4, '0);
    ahb_xfer(1, 32'((NCFG+NSTA)*4), 1'b1, 3'd2, 32'h4, 1'b0, '0, 32'h4);
    ahb_xfer(1, 32'((NCFG+NSTA)*4), 1'b0, 3'd2, '0, 1'b0, 32'h4, '0);
    check("irq_held", 64'(irq_w[1]), 64'h1);
    ahb_xfer(1, 32'((NCFG+NSTA)*4), 1'b1, 3'd2, 32'h4, 1'b0, '0, '0);
    check("irq_fall_lag", 64'(irq_w[1]), 64'h1);
    @(posedge clk); #1;
    check("irq_cleared", 64'(irq_w[1]), 64'h0);
    ahb_xfer(1, 32'((NCFG+NSTA)*4), 1'b0, 3'd2, '0, 1'b0, 32'h0, '0);
    ahb_xfer(1, 32'((NCFG+NSTA+1)*4), 1'b0, 3'd2, '0, 1'b0, 32'h4, '0);

    // Back-to-back write then read on the zero-wait slave.
    haddr = 32'h8; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10; hsel[0] = 1'b1;
    @(posedge clk); #1;
    check("b2b_wr_ready", 64'(hready_w[0]), 64'h1);
    hwdata = 32'hCAFEF00D;
    hwrite = 1'b0;
    exp_q.push_back(32'hCAFEF00D);
    @(posedge clk); #1;
    htrans = 2'b00; hsel[0] = 1'b0;
    check("b2b_rd_ready", 64'(hready_w[0]), 64'h1);
    if (exp_q.size() == 0) check("sb_underflow", 64'h1, 64'h0);
    else check("b2b_rdata", 64'(hrdata_w[0]), 64'(exp_q.pop_front()));
    @(posedge clk); #1;
    check("b2b_idle", 64'(dbg_w[0]), 64'h0);

    // Reset in the middle of a waited data phase.
    haddr = 32'hC; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10; hsel[1] = 1'b1;
    @(posedge clk); #1;
    htrans = 2'b00; hsel[1] = 1'b0; hwdata = 32'h12345678;
    check("mid_wait_ready", 64'(hready_w[1]), 64'h0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 64'(hready_w[1]), 64'h1);
    check("mid_rst_state", 64'(dbg_w[1]), 64'h0);
    check("mid_rst_cfg1", 64'(cfg_w[1][63:32]), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mid_rst_cfg3", 64'(cfg_w[1][127:96]), 64'h0);
    check("sb_drain", 64'(exp_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ddr_ahb_csr_bank.md
# ddr_ahb_csr_bank

Parametrised AHB-Lite slave with a built-in CSR bank, the next-generation replacement for the fixed slave-plus-register-file pairing used by the DFI CSR blocks. It provides NCFG read/write config words, NSTA read-only status words, and one sticky W1C event word with an interrupt mask. It also adds configurable wait states, byte/halfword write lanes and AHB two-cycle ERROR responses. Sits between the AHB interconnect and any DDR sub-block needing cfg/status/event registers.

## Interface
- AWIDTH, 32: address width.
- DWIDTH, 32: data width; must be 32 or 64.
- NCFG, 16: number of RW config words (1..64).
- NSTA, 8: number of RO status words (0..64).
- WAIT_STATES, 0: hready-low cycles inserted per data phase (0..3).
- CFG_RST, 0: NCFG*DWIDTH-bit reset image of the config words; word k occupies [k*DWIDTH +: DWIDTH].
- i_hclk  in  1  single clock for the whole block.
- i_hreset  in  1  asynchronous, active-low reset.
- i_haddr  in  AWIDTH  AHB address.
- i_hwrite  in  1  AHB write.
- i_hsel  in  1  slave select.
- i_hwdata  in  DWIDTH  write data, sampled in the data phase.
- i_htrans  in  2  AHB transfer type.
- i_hsize  in  3  transfer size.
- i_hburst  in  3  accepted and ignored; each beat is decoded independently.
- i_hreadyin  in  1  bus ready.
- o_hready  out  1  slave ready.
- o_hrdata  out  DWIDTH  read data.
- o_hresp  out  2  00 OKAY, 01 ERROR.
- o_cfg  out  NCFG*DWIDTH  config words, registered.
- i_sta  in  NSTA*DWIDTH  status words, sampled on read.
- i_evt  in  DWIDTH  per-bit event pulses.
- o_irq  out  1  OR of masked sticky events, registered.

## Operation
- Accept the address phase when i_hsel & i_hreadyin & i_htrans[1] (NONSEQ/SEQ). On acceptance, register haddr, hwrite and hsize.
- IDLE/BUSY transfers and unselected cycles get an OKAY zero-wait response and cause no register access.
- Word index is haddr >> log2(DWIDTH/8). Index map:
  - 0..NCFG-1: CFG.
  - NCFG..NCFG+NSTA-1: STA.
  - NCFG+NSTA: EVT.
  - NCFG+NSTA+1: EVT_MASK.
- The following cause ERROR with no side effect:
  - index beyond EVT_MASK;
  - hsize wider than DWIDTH;
  - address not aligned to hsize.
- Writes:
  - Byte lanes are enabled from hsize and the low address bits. Only enabled lanes update.
  - A STA write is an OKAY response and is ignored.
  - An EVT write clears the bits written 1 (W1C).
- Reads return the full word. STA reads return i_sta as sampled in the final data-phase cycle.
- EVT update each cycle: evt <= (evt & ~w1c) | i_evt. A set wins over a simultaneous clear.
- o_irq <= |(evt & evt_mask).
- FSM:
  - IDLE → WAIT when an access is accepted and WAIT_STATES>0; IDLE → DATA when WAIT_STATES=0; IDLE → ERR1 on an error decode.
  - WAIT counts WAIT_STATES cycles, then → DATA.
  - DATA completes the transfer. It → IDLE, or accepts the next pipelined address phase in the same cycle (back-to-back).
  - ERR1 → ERR2 → IDLE, or ERR2 accepts the next address phase.
- Reset mid-transfer: the transfer is abandoned. All state and outputs take their reset values immediately.

## Timing
- Reset values:
  - o_hready=1, o_hresp=00, o_hrdata=0, o_irq=0;
  - o_cfg=CFG_RST;
  - EVT=0, EVT_MASK=0;
  - FSM in IDLE.
- Data phase length is WAIT_STATES+1 cycles:
  - o_hready is low for the first WAIT_STATES cycles and high in the final cycle.
  - o_hrdata is valid in the final cycle.
- A write commits on the clock edge ending the final data-phase cycle, using i_hwdata from that cycle. o_cfg reflects the new value in the next cycle.
- ERROR response:
  - ERR1: o_hresp=01, o_hready=0.
  - ERR2: o_hresp=01, o_hready=1.
- o_irq lags an event by 1 cycle after evt sets, i.e. 2 cycles after the i_evt pulse.
- With WAIT_STATES=0, back-to-back transfers sustain 1 transfer per cycle.

## Test plan
- Reset values: assert i_hreset=0 with CFG_RST word0=0xDEADBEEF → o_cfg word0=0xDEADBEEF, o_hready=1, o_hresp=00, o_irq=0.
- Byte write, then read back: WAIT_STATES=2, write word 1 = 0x11223344, then a byte write of 0xAA to addr 0x6 → reading word 1 returns 0x11AA3344; o_hready is low for exactly 2 cycles per data phase.
- STA read and write: set i_sta word0=0x5A5A0001 and read index NCFG → returns 0x5A5A0001. A write to the same index → OKAY response, read value unchanged.
- Out-of-range access: read index NCFG+NSTA+2 → two-cycle ERROR (01/low, then 01/high), no register change. The following NONSEQ access completes OKAY.
- Events and interrupt: set EVT_MASK=0x4, pulse i_evt bit2 → EVT=0x4 and o_irq=1 two cycles later. Write EVT=0x4 in the same cycle as another i_evt bit2 pulse → bit stays set. A later write EVT=0x4 → EVT=0, and o_irq falls one cycle after the clear.
- Back-to-back transfers: WAIT_STATES=0, issue write A then read A in consecutive cycles → the read returns the new data with no stall.
